// File: rtl/mux_share_pkg.sv
// Shared types and defaults for the two-requester mux-sharing arbiter.
package mux_share_pkg;

  localparam int DEFAULT_DATA_W = 8;

  // Grant state: the encoding is visible on the debug state port.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } state_t;

  // Winner of a fresh arbitration out of IDLE. Ties go to the requester
  // the priority pointer names.
  function automatic state_t pick_grant(input logic a_valid,
                                        input logic b_valid,
                                        input logic prio_b);
    state_t g;
    g = IDLE;
    if (a_valid && b_valid) begin
      g = prio_b ? GNT_B : GNT_A;
    end else if (a_valid) begin
      g = GNT_A;
    end else if (b_valid) begin
      g = GNT_B;
    end
    return g;
  endfunction

endpackage

// File: rtl/share_mux2.sv
// Purely combinational 2:1 mux for one {data, last, valid} beat.
module share_mux2 #(
  parameter int DATA_W = mux_share_pkg::DEFAULT_DATA_W
) (
  input  logic              sel_b,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  input  logic              b_valid,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              valid
);

  // Select B when sel_b is high, A otherwise.
  always_comb begin
    data  = sel_b ? b_data  : a_data;
    last  = sel_b ? b_last  : a_last;
    valid = sel_b ? b_valid : a_valid;
  end

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter owning a shared 2:1 data mux and its sink.
// Packets are locked to one requester until their last beat.
//
// Handshake: on every side a beat moves in a cycle where valid and ready
// are both high at the rising edge. Valid never depends on ready. Here a
// requester's ready is the sink's out_ready, passed through only while
// that requester holds the grant; the non-granted ready is always 0.
module mux_share_arbiter
  import mux_share_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel_b,
  output logic              busy,
  output state_t            state,
  output logic              prio_b
);

  state_t state_q;
  state_t state_d;
  logic   prio_q;
  logic   prio_d;
  logic   sel_q;
  logic   busy_q;

  logic              mux_valid;
  logic              mux_last;
  logic [DATA_W-1:0] mux_data;

  // Next grant and priority: hold through non-last beats and stalls,
  // hand off (or drop to IDLE) only on an accepted last beat.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        state_d = pick_grant(a_valid, b_valid, prio_q);
      end
      GNT_A: begin
        if (a_valid && out_ready && a_last) begin
          prio_d  = 1'b1;
          state_d = b_valid ? GNT_B : IDLE;
        end
      end
      GNT_B: begin
        if (b_valid && out_ready && b_last) begin
          prio_d  = 1'b0;
          state_d = a_valid ? GNT_A : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, priority pointer and registered select/busy, with sync reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sel_q   <= (state_d == GNT_B);
      busy_q  <= (state_d != IDLE);
    end
  end

  share_mux2 #(
    .DATA_W (DATA_W)
  ) u_mux (
    .sel_b   (sel_q),
    .a_data  (a_data),
    .a_last  (a_last),
    .a_valid (a_valid),
    .b_data  (b_data),
    .b_last  (b_last),
    .b_valid (b_valid),
    .data    (mux_data),
    .last    (mux_last),
    .valid   (mux_valid)
  );

  // Present the granted beat; in IDLE the mux sits on A and valid/last
  // are masked so the sink sees nothing.
  always_comb begin
    out_data  = mux_data;
    out_valid = busy_q & mux_valid;
    out_last  = busy_q & mux_last;
    a_ready   = (state_q == GNT_A) & out_ready;
    b_ready   = (state_q == GNT_B) & out_ready;
  end

  assign sel_b  = sel_q;
  assign busy   = busy_q;
  assign state  = state_q;
  assign prio_b = prio_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Bench for mux_share_arbiter: directed vector table, then randomized
// traffic compared against a grant-ownership model.
module tb_mux_share_arbiter;

  localparam int W = 8;
  localparam int N_TBL = 28;
  localparam int N_RND = 600;

  logic         clk;
  logic         resetn;
  logic         a_valid, a_last, a_ready;
  logic [W-1:0] a_data;
  logic         b_valid, b_last, b_ready;
  logic [W-1:0] b_data;
  logic         out_valid, out_last, out_ready;
  logic [W-1:0] out_data;
  logic         sel_b, busy, prio_b;
  logic [1:0]   state;

  int n_vec;
  int n_bad;

  typedef struct {
    logic         rn;
    logic         av;
    logic [W-1:0] ad;
    logic         al;
    logic         bv;
    logic [W-1:0] bd;
    logic         bl;
    logic         ordy;
    logic         e_ov;
    logic [W-1:0] e_od;
    logic         e_ol;
    logic         e_ar;
    logic         e_br;
    logic         e_sel;
    logic         e_busy;
    logic [1:0]   e_st;
    logic         e_prio;
  } vec_t;

  vec_t tbl[N_TBL];

  // Reference model: who holds the grant (0 none, 1 A, 2 B) and who was
  // the last requester to finish a packet (ties go to the other one).
  int owner;
  int last_served;

  mux_share_arbiter #(.DATA_W(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_last    (a_last),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_last    (b_last),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel_b     (sel_b),
    .busy      (busy),
    .state     (state),
    .prio_b    (prio_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic rn, input logic av, input logic [W-1:0] ad,
                       input logic al, input logic bv, input logic [W-1:0] bd,
                       input logic bl, input logic ordy);
    resetn    = rn;
    a_valid   = av;
    a_data    = ad;
    a_last    = al;
    b_valid   = bv;
    b_data    = bd;
    b_last    = bl;
    out_ready = ordy;
  endtask

  task automatic check(input string name, input int idx, input logic ov,
                       input logic [W-1:0] od, input logic ol, input logic ar,
                       input logic br, input logic sel, input logic bsy,
                       input logic [1:0] st, input logic pr);
    logic [W+9:0] got;
    logic [W+9:0] exp;
    got = {out_valid, out_data, out_last, a_ready, b_ready, sel_b, busy, state, prio_b};
    exp = {ov, od, ol, ar, br, sel, bsy, st, pr};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got ov=%b od=%h ol=%b ar=%b br=%b sel=%b busy=%b st=%0d prio=%b, expected ov=%b od=%h ol=%b ar=%b br=%b sel=%b busy=%b st=%0d prio=%b",
               name, idx, out_valid, out_data, out_last, a_ready, b_ready, sel_b, busy, state, prio_b,
               ov, od, ol, ar, br, sel, bsy, st, pr);
    end
  endtask

  // Advance the model by one rising edge using the inputs of this cycle.
  task automatic model_step();
    int want_a, want_b, x_valid, x_last, other_valid;
    if (!resetn) begin
      owner = 0;
      last_served = 2;
    end else if (owner == 0) begin
      want_a = int'(a_valid);
      want_b = int'(b_valid);
      if (want_a + want_b == 2) owner = 3 - last_served;
      else if (want_a == 1)     owner = 1;
      else if (want_b == 1)     owner = 2;
    end else begin
      x_valid     = (owner == 1) ? int'(a_valid) : int'(b_valid);
      x_last      = (owner == 1) ? int'(a_last)  : int'(b_last);
      other_valid = (owner == 1) ? int'(b_valid) : int'(a_valid);
      if (x_valid == 1 && out_ready && x_last == 1) begin
        last_served = owner;
        owner = (other_valid == 1) ? 3 - owner : 0;
      end
    end
  endtask

  task automatic model_check(input int idx);
    logic ov, ol;
    logic [W-1:0] od;
    ov = (owner == 1) ? a_valid : (owner == 2) ? b_valid : 1'b0;
    ol = (owner == 1) ? a_last  : (owner == 2) ? b_last  : 1'b0;
    od = (owner == 2) ? b_data  : a_data;
    check("rand", idx, ov, od, ol, (owner == 1) && out_ready, (owner == 2) && out_ready,
          owner == 2, owner != 0, 2'(owner), last_served == 1);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    owner = 0;
    last_served = 2;

    //            rn av ad     al bv bd     bl or | ov od     ol ar br sl by st  pr
    // A alone, 3-beat packet, back to IDLE.
    tbl[0]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 2'd0, 0};
    tbl[1]  = '{1, 1, 8'h11, 0, 0, 8'h00, 0, 1,   0, 8'h11, 0, 0, 0, 0, 0, 2'd0, 0};
    tbl[2]  = '{1, 1, 8'h11, 0, 0, 8'h00, 0, 1,   1, 8'h11, 0, 1, 0, 0, 1, 2'd1, 0};
    tbl[3]  = '{1, 1, 8'h12, 0, 0, 8'h00, 0, 1,   1, 8'h12, 0, 1, 0, 0, 1, 2'd1, 0};
    tbl[4]  = '{1, 1, 8'h13, 1, 0, 8'h00, 0, 1,   1, 8'h13, 1, 1, 0, 0, 1, 2'd1, 0};
    tbl[5]  = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0, 0, 0, 2'd0, 1};
    // Reset, then both request: A first, B with no bubble.
    tbl[6]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 2'd0, 1};
    tbl[7]  = '{1, 1, 8'hA1, 0, 1, 8'hB1, 0, 1,   0, 8'hA1, 0, 0, 0, 0, 0, 2'd0, 0};
    tbl[8]  = '{1, 1, 8'hA2, 1, 1, 8'hB1, 0, 1,   1, 8'hA2, 1, 1, 0, 0, 1, 2'd1, 0};
    tbl[9]  = '{1, 0, 8'h00, 0, 1, 8'hB1, 0, 1,   1, 8'hB1, 0, 0, 1, 1, 1, 2'd2, 1};
    tbl[10] = '{1, 0, 8'h00, 0, 1, 8'hB2, 1, 1,   1, 8'hB2, 1, 0, 1, 1, 1, 2'd2, 1};
    tbl[11] = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0, 0, 0, 2'd0, 0};
    // B alone 1-beat, then both request: A wins.
    tbl[12] = '{1, 0, 8'h00, 0, 1, 8'hC1, 1, 1,   0, 8'h00, 0, 0, 0, 0, 0, 2'd0, 0};
    tbl[13] = '{1, 0, 8'h00, 0, 1, 8'hC1, 1, 1,   1, 8'hC1, 1, 0, 1, 1, 1, 2'd2, 0};
    tbl[14] = '{1, 1, 8'hD1, 0, 1, 8'hE1, 0, 1,   0, 8'hD1, 0, 0, 0, 0, 0, 2'd0, 0};
    // GNT_A stalled by the sink for 4 cycles.
    tbl[15] = '{1, 1, 8'hD1, 0, 1, 8'hE1, 0, 0,   1, 8'hD1, 0, 0, 0, 0, 1, 2'd1, 0};
    tbl[16] = '{1, 1, 8'hD1, 0, 1, 8'hE1, 0, 0,   1, 8'hD1, 0, 0, 0, 0, 1, 2'd1, 0};
    tbl[17] = '{1, 1, 8'hD1, 0, 1, 8'hE1, 0, 0,   1, 8'hD1, 0, 0, 0, 0, 1, 2'd1, 0};
    tbl[18] = '{1, 1, 8'hD1, 0, 1, 8'hE1, 0, 0,   1, 8'hD1, 0, 0, 0, 0, 1, 2'd1, 0};
    // A drops valid mid-packet while B waits: grant stays with A.
    tbl[19] = '{1, 1, 8'hD1, 0, 1, 8'hE1, 0, 1,   1, 8'hD1, 0, 1, 0, 0, 1, 2'd1, 0};
    tbl[20] = '{1, 0, 8'h00, 0, 1, 8'hE1, 0, 1,   0, 8'h00, 0, 1, 0, 0, 1, 2'd1, 0};
    tbl[21] = '{1, 0, 8'h00, 0, 1, 8'hE1, 0, 1,   0, 8'h00, 0, 1, 0, 0, 1, 2'd1, 0};
    tbl[22] = '{1, 1, 8'hD2, 1, 1, 8'hE1, 0, 1,   1, 8'hD2, 1, 1, 0, 0, 1, 2'd1, 0};
    // Reset during GNT_B beat 2: packet abandoned, then restarted.
    tbl[23] = '{1, 0, 8'h00, 0, 1, 8'hE1, 0, 1,   1, 8'hE1, 0, 0, 1, 1, 1, 2'd2, 1};
    tbl[24] = '{0, 0, 8'h00, 0, 1, 8'hE2, 0, 1,   1, 8'hE2, 0, 0, 1, 1, 1, 2'd2, 1};
    tbl[25] = '{1, 0, 8'h00, 0, 1, 8'hE2, 0, 1,   0, 8'h00, 0, 0, 0, 0, 0, 2'd0, 0};
    tbl[26] = '{1, 0, 8'h00, 0, 1, 8'hE1, 1, 1,   1, 8'hE1, 1, 0, 1, 1, 1, 2'd2, 0};
    tbl[27] = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0, 0, 0, 2'd0, 0};

    // Reset
    drive(0, 0, '0, 0, 0, '0, 0, 0);
    repeat (2) @(posedge clk);

    // Directed vectors
    for (int i = 0; i < N_TBL; i++) begin
      @(negedge clk);
      drive(tbl[i].rn, tbl[i].av, tbl[i].ad, tbl[i].al,
            tbl[i].bv, tbl[i].bd, tbl[i].bl, tbl[i].ordy);
      #1;
      check("tbl", i, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_ol, tbl[i].e_ar, tbl[i].e_br,
            tbl[i].e_sel, tbl[i].e_busy, tbl[i].e_st, tbl[i].e_prio);
    end

    // Randomized traffic; the first cycle resets to a known model state.
    for (int k = 0; k < N_RND; k++) begin
      @(negedge clk);
      drive((k == 0) ? 1'b0 : ($urandom_range(0, 63) != 0),
            ($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) != 0));
      #1;
      model_check(k);
      @(posedge clk);
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
